ysyx_25010008_clint: RTL and testbench
======================================

# ysyx_25010008_clint

Core-local interruptor (timer-only subset) for the ysyx_25010008 SoC. It maintains a free-running 64-bit `mtime` counter and exposes it as two read-only 32-bit registers over a read-only AXI4-Lite slave port (AR and R channels only). It sits behind the core's memory arbiter, which routes reads of 0xa000_0048 and 0xa000_004c here and all other traffic to the external bus.

## Interface
- `MTIME_LO_ADDR`, default 32'ha000_0048, byte address of `mtime[31:0]`.
- `MTIME_HI_ADDR`, default 32'ha000_004c, byte address of `mtime[63:32]`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `araddr`  in  32  read address.
- `arvalid`  in  1  read-address valid.
- `arready`  out  1  read-address ready.
- `rready`  in  1  read-data ready from master.
- `rdata`  out  32  read data.
- `rresp`  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
- `rvalid`  out  1  read-data valid.

## Operation
- `mtime`: 64-bit unsigned counter, +1 on every rising edge while `reset` is low; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0. Not writable; no write channels exist.
- FSM states:
  - IDLE: `arready`=1, `rvalid`=0.
  - RESP: `arready`=0, `rvalid`=1.
- IDLE -> RESP on an edge with `arvalid`&`arready`. At that edge, `rdata`/`rresp` are registered from `araddr` and the pre-edge `mtime` value:
  - `araddr`==`MTIME_LO_ADDR`: `rdata`=`mtime[31:0]`, `rresp`=00.
  - `araddr`==`MTIME_HI_ADDR`: `rdata`=`mtime[63:32]`, `rresp`=00.
  - Any other address: `rdata`=0, `rresp`=10 (SLVERR).
- Full 32-bit address compare; no aliasing.
- RESP -> IDLE on an edge with `rvalid`&`rready`.
- While in RESP, `rdata`/`rresp` are held stable until the handshake, and `arvalid` is ignored.
- No snapshot between halves. Software reads hi/lo/hi to handle carry between the two reads.

## Timing
- Reset (asynchronous, immediate): `mtime`=0, state=IDLE, `arready`=1, `rvalid`=0, `rdata`=0, `rresp`=0.
- Counting: edge k after reset release (k=1,2,…) leaves `mtime`=k. An AR handshake at edge k captures `mtime`=k-1.
- Latency: AR handshake at edge k -> `rvalid`=1 in the cycle after edge k. Minimum one cycle from AR accept to R valid.
- Back-to-back reads: R handshake at edge m -> `arready`=1 after edge m; next AR accepted at edge m+1 at the earliest. Throughput is at most one read per 2 cycles.
- `arready` and `rvalid` are pure state decodes (registered); no combinational path from any input.
- `rready` held low: `rvalid` stays 1 indefinitely and `mtime` keeps counting.
- `reset` asserted during RESP: response aborted, `rvalid` drops without a handshake, and the state returns to IDLE.
- `arvalid` high in the same cycle reset deasserts: accepted at the first edge with reset low, returning `mtime`=0.

## Test plan
- Reset, then hold idle: `arready`=1, `rvalid`=0, `rdata`=0, `rresp`=0. Assert `reset` mid-run: all outputs return to these values without waiting for a clock edge.
- Release reset, assert `arvalid` with `araddr`=0xa000_0048 so the AR handshake lands on edge 10, `rready`=1: `rvalid`=1 for exactly one cycle with `rdata`=9, `rresp`=00.
- Read 0xa000_004c shortly after reset: `rdata`=0, `rresp`=00. Then force/preload `mtime`=0x0000_0000_FFFF_FFFE, read lo at the next edge: 0xFFFF_FFFE. Read hi two reads later: `rdata`=1.
- Read 0xa000_0050: `rdata`=0, `rresp`=10, `arready` returns to 1 after the R handshake.
- Hold `rready`=0 for 5 cycles after `rvalid` rises: `rvalid`, `rdata` and `rresp` stay stable and `arready`=0. A second `arvalid` in this window is not accepted. Raising `rready` completes the handshake, and the pending AR is accepted one edge later.
- Preload `mtime`=0xFFFF_FFFF_FFFF_FFFF: after one edge, reading lo returns 0 and reading hi returns 0.

Source files
------------

// File: rtl/ysyx_25010008_clint.sv
// ============================================================================
// Module      : ysyx_25010008_clint
// Description : Timer-only core-local interruptor; 64-bit mtime read over AXI4-Lite AR/R.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ysyx_25010008_clint #(
    parameter logic [31:0] MTIME_LO_ADDR = 32'ha000_0048,
    parameter logic [31:0] MTIME_HI_ADDR = 32'ha000_004c
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_mtime;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic [31:0] w_rdata_sel;
    logic [1:0]  w_rresp_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mtime <= 64'd0;
        end else begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // Exact 32-bit match only; every other address answers SLVERR with zero data.
    always_comb begin
        w_rdata_sel = 32'd0;
        w_rresp_sel = c_RESP_SLVERR;
        if (araddr == MTIME_LO_ADDR) begin
            w_rdata_sel = r_mtime[31:0];
            w_rresp_sel = c_RESP_OKAY;
        end else if (araddr == MTIME_HI_ADDR) begin
            w_rdata_sel = r_mtime[63:32];
            w_rresp_sel = c_RESP_OKAY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_rresp   <= c_RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_state   <= S_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rdata_sel;
                        r_rresp   <= w_rresp_sel;
                    end
                end
                S_RESP: begin
                    if (r_rvalid && rready) begin
                        r_state   <= S_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25010008_clint.sv
// ============================================================================
// Module      : tb_ysyx_25010008_clint
// Description : Self-checking bench for the CLINT mtime read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25010008_clint;

    localparam logic [31:0] c_LO = 32'ha000_0048;
    localparam logic [31:0] c_HI = 32'ha000_004c;

    logic        clock;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;

    int checks = 0;
    int errors = 0;

    // Reference time = preload value plus rising edges seen since the preload.
    logic [63:0] edges;
    logic [63:0] base;
    logic [63:0] pre_edges;

    ysyx_25010008_clint #(
        .MTIME_LO_ADDR(c_LO),
        .MTIME_HI_ADDR(c_HI)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) edges <= 64'd0;
        else       edges <= edges + 64'd1;
    end

    function automatic logic [63:0] model_time();
        return base + (edges - pre_edges);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".arready"}, {63'd0, arready}, 64'd1);
        chk({tag, ".rvalid"},  {63'd0, rvalid},  64'd0);
    endtask

    // Entered at a negedge in IDLE; returns at a negedge after the R handshake.
    task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
        logic [63:0] t;
        logic [31:0] ed;
        logic [1:0]  er;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        chk({tag, ".ar_ready"}, {63'd0, arready}, 64'd1);
        t  = model_time();
        ed = (addr == c_LO) ? t[31:0] : (addr == c_HI) ? t[63:32] : 32'd0;
        er = (addr == c_LO || addr == c_HI) ? 2'b00 : 2'b10;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        chk({tag, ".rvalid"}, {63'd0, rvalid}, 64'd1);
        chk({tag, ".rdata"},  {32'd0, rdata},  {32'd0, ed});
        chk({tag, ".rresp"},  {62'd0, rresp},  {62'd0, er});
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, ".hold_rvalid"}, {63'd0, rvalid}, 64'd1);
            chk({tag, ".hold_rdata"},  {32'd0, rdata},  {32'd0, ed});
            chk({tag, ".hold_arready"}, {63'd0, arready}, 64'd0);
        end
        rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready = 1'b0;
        expect_idle({tag, ".post"});
    endtask

    task automatic preload(input logic [63:0] v);
        force dut.r_mtime = v;
        #1;
        release dut.r_mtime;
        base      = v;
        pre_edges = edges;
    endtask

    initial begin
        logic [63:0] t;
        logic [31:0] a;
        logic [31:0] held;
        reset = 1'b1; araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
        base = 64'd0; pre_edges = 64'd0;
        #1;
        expect_idle("reset");
        chk("reset.rdata", {32'd0, rdata}, 64'd0);
        chk("reset.rresp", {62'd0, rresp}, 64'd0);
        repeat (3) @(negedge clock);
        expect_idle("reset_hold");

        // AR handshake on edge 10 after release, rready already high
        reset = 1'b0;
        repeat (9) @(negedge clock);
        araddr = c_LO; arvalid = 1'b1; rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        chk("edge10.rvalid", {63'd0, rvalid}, 64'd1);
        chk("edge10.rdata",  {32'd0, rdata},  64'd9);
        chk("edge10.rresp",  {62'd0, rresp},  64'd0);
        @(negedge clock);
        rready = 1'b0;
        chk("edge10.one_cycle", {63'd0, rvalid}, 64'd1 - 64'd1);
        chk("edge10.arready",   {63'd0, arready}, 64'd1);

        // Asynchronous reset in the middle of a pending response
        araddr = c_HI; arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        chk("pre_async.rvalid", {63'd0, rvalid}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        expect_idle("async_reset");
        chk("async_reset.rdata", {32'd0, rdata}, 64'd0);
        chk("async_reset.rresp", {62'd0, rresp}, 64'd0);
        base = 64'd0; pre_edges = 64'd0;

        // arvalid present as reset releases: first edge returns mtime 0
        @(negedge clock);
        reset = 1'b0; araddr = c_LO; arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        chk("rel.rvalid", {63'd0, rvalid}, 64'd1);
        chk("rel.rdata",  {32'd0, rdata},  64'd0);
        chk("rel.rresp",  {62'd0, rresp},  64'd0);
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;

        do_read(c_HI, 0, "hi_early");
        chk("hi_early.value", {32'd0, rdata}, 64'd0);

        // Carry from lo into hi
        preload(64'h0000_0000_FFFF_FFFE);
        do_read(c_LO, 0, "carry_lo");
        chk("carry_lo.value", {32'd0, rdata}, 64'h0000_0000_FFFF_FFFE);
        do_read(c_LO, 0, "carry_lo2");
        do_read(c_HI, 0, "carry_hi");
        chk("carry_hi.value", {32'd0, rdata}, 64'd1);

        do_read(32'ha000_0050, 1, "bad_addr");

        // Stalled response with a second AR pending
        @(negedge clock);
        araddr = c_LO; arvalid = 1'b1; rready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        held = rdata;
        araddr = c_HI;
        for (int i = 0; i < 5; i++) begin
            chk("stall.rvalid",  {63'd0, rvalid},  64'd1);
            chk("stall.arready", {63'd0, arready}, 64'd0);
            chk("stall.rdata",   {32'd0, rdata},   {32'd0, held});
            chk("stall.rresp",   {62'd0, rresp},   64'd0);
            @(negedge clock);
        end
        rready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rready = 1'b0;
        expect_idle("stall.release");
        t = model_time();
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        chk("pending.rvalid", {63'd0, rvalid}, 64'd1);
        chk("pending.rdata",  {32'd0, rdata},  {32'd0, t[63:32]});
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;

        // 64-bit wrap
        preload(64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock);
        do_read(c_LO, 0, "wrap_lo");
        chk("wrap_lo.value", {32'd0, rdata}, 64'd0);
        do_read(c_HI, 0, "wrap_hi");
        chk("wrap_hi.value", {32'd0, rdata}, 64'd0);

        // Randomized reads against the reference time
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       a = c_LO;
                1:       a = c_HI;
                2:       a = c_LO + 32'd8;
                default: a = $urandom;
            endcase
            if (n == 12) preload({$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_read(a, $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
